seq_detect_sched: RTL and testbench
===================================

# seq_detect_sched

Time-multiplexed scheduler for the two-ones sequence-detector engine. Up to NCH serial bit streams share a single detector next-state datapath. Each channel keeps its own 2-bit detector context, and a round-robin arbiter selects one channel per cycle. Hits are reported as a channel-tagged pulse, and per-channel saturating hit counters are readable for debug and status.

## Interface
Parameters:
- NCH, 4 — number of requesting channels, 2..16.
- CNT_W, 8 — width of each per-channel hit counter.

Ports:
- clk  in  1 — clock, rising edge.
- rst_n  in  1 — reset, asynchronous, active-low.
- bit_valid  in  NCH — channel i presents a bit.
- bit_data  in  NCH — bit value for channel i.
- bit_ready  out  NCH — channel i's bit is consumed this cycle. One-hot or zero.
- ch_en  in  NCH — channel enable. A disabled channel is never granted and its context is held.
- ch_clr  in  NCH — synchronous clear pulse. Resets the channel's context to S0 and its counter to 0.
- hit_valid  out  1 — one-cycle, registered hit pulse.
- hit_ch  out  $clog2(NCH) — channel of the hit. Meaningful only when hit_valid is high.
- cnt_sel  in  $clog2(NCH) — counter read select.
- cnt_rdata  out  CNT_W — hit counter of channel cnt_sel. Combinational from registers.

## Operation
- Per-channel context state_t ∈ {S0, S1, S2, S3}. Step function on accepted bit b:
  - S0: b ? S1 : S0
  - S1: b ? S2 : S0
  - S2: b ? S3 : S0
  - S3: b ? S3 : S0
- Hit condition: the stepped next context equals S2. This is the second consecutive 1 after a 0 or after a clear. Further 1s move the context to S3 and hold it there, so a run of 1s yields exactly one hit.
- Eligibility of channel i: bit_valid[i] & ch_en[i] & ~ch_clr[i].
- Arbitration:
  - Round-robin pointer ptr. Grant goes to the first eligible channel at or after ptr, wrapping modulo NCH.
  - bit_ready = grant. At most one bit is consumed per cycle.
  - On a grant to channel g, ptr moves to (g+1) mod NCH. With no grant, ptr holds.
- On grant:
  - The context of channel g is replaced by the step result.
  - If that result is a hit, counter[g] increments, saturating at 2^CNT_W−1.
  - If that result is a hit, hit_valid is set next cycle and hit_ch = g.
  - If there is no hit, hit_valid is low next cycle.
- Clear:
  - ch_clr[i] forces context[i] to S0 and counter[i] to 0 at the next edge.
  - It also masks channel i from arbitration that cycle, so clear always wins over a simultaneous grant.
  - Multiple clears in one cycle are independent.
- Disabling a channel (ch_en low) preserves its context and counter. Matching resumes from the saved context when it is re-enabled.
- Contexts of non-granted channels never change, except by clear.

## Timing
- Reset values:
  - All contexts S0, all counters 0.
  - ptr = 0.
  - hit_valid = 0, hit_ch = 0.
  - bit_ready is combinational. It is 0 while no channel is eligible.
- bit_ready is a combinational function of bit_valid, ch_en, ch_clr and ptr. Requesters must not derive bit_valid from bit_ready.
- A bit is accepted in cycle t when bit_valid[i] & bit_ready[i]. The context update happens at the end of cycle t.
- Hit latency: hit_valid and hit_ch are high in cycle t+1 for exactly one cycle. Back-to-back hits on different channels in consecutive cycles are allowed.
- cnt_rdata reflects the increment from cycle t starting in cycle t+1. It reflects a clear issued in cycle t starting in cycle t+1.
- Throughput: one bit per cycle aggregate. Worst-case wait for a continuously valid, enabled channel is NCH−1 cycles.
- Asynchronous reset mid-stream discards all contexts, counters and any pending hit pulse immediately. The first post-reset grant goes to the lowest eligible index.

## Structure
- Package seq_detect_pkg holds:
  - typedef enum logic [1:0] state_t {S0, S1, S2, S3};
  - function seq_step(state_t, logic) returning the next state;
  - function is_hit(state_t next), which is true iff next == S2.
- Sub-module rr_arb #(N): eligibility vector plus ptr in, one-hot grant and grant index out, ptr register internal. The context array, counters and hit register live in seq_detect_sched.

## Test plan
- Single-channel pattern: NCH=4, only ch0 enabled and valid, bits 0,1,1,1,0,1,1.
  - hit_valid pulses exactly twice, one cycle after the 3rd and 7th accepted bits, with hit_ch=0.
  - cnt_rdata(sel 0) reads 2.
- Fairness: all 4 channels continuously valid.
  - Grants go 0,1,2,3,0,… with bit_ready one-hot every cycle.
  - With ch2 disabled, the sequence is 0,1,3,0,1,3.
- Context isolation: ch1 and ch3 are interleaved. ch1 is fed 1, ch3 is fed 0, then ch1 is fed 1.
  - A hit occurs on hit_ch=1 only.
  - ch3's context stays S0.
- Clear priority: ch0 sits in S1, then ch_clr[0] and bit_valid[0]=1 are asserted in the same cycle.
  - bit_ready[0]=0 that cycle.
  - The next accepted 1 gives no hit, and the second accepted 1 gives a hit.
  - The counter reads 0 right after the clear.
- Saturation: CNT_W=2, drive 5 hits on ch0.
  - The counter reads 3 and stays at 3.
  - hit_valid still pulses on every hit.
- Reset mid-operation: assert rst_n low while ch0 is in S1 and hit_valid is high.
  - hit_valid drops immediately.
  - After release, a single 1 on ch0 gives no hit.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and step logic for the two-ones sequence detector.
// The detector context is a 2-bit state; a hit is the move into S2.
package seq_detect_pkg;

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    function automatic state_t seq_step(input state_t s, input logic b);
        state_t n;
        case (s)
            S0:      n = b ? S1 : S0;
            S1:      n = b ? S2 : S0;
            S2:      n = b ? S3 : S0;
            S3:      n = b ? S3 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic logic is_hit(input state_t n);
        return (n == S2);
    endfunction

endpackage

// File: rtl/seq_detect_sched_arb.sv
// Round-robin arbiter: grants the first eligible requester at or after
// the pointer, then moves the pointer just past the winner.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_elig,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_vld
);

    localparam logic [IW:0] L_N = (IW+1)'(N);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic          w_vld;

    // Rotate requests so the pointer position lands at bit 0.
    always_comb begin
        w_rot = N'({i_elig, i_elig} >> r_ptr);
        w_off = '0;
        w_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_vld = 1'b1;
                w_off = IW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= L_N) begin
            w_sum = w_sum - L_N;
        end
        w_idx = w_sum[IW-1:0];
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = w_vld && (w_idx == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_vld) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_grant_idx = w_idx;
    assign o_grant_vld = w_vld;

endmodule

// File: rtl/seq_detect_sched.sv
// Time-multiplexed two-ones detector: NCH serial streams share one step
// datapath under round-robin arbitration, with per-channel hit counters.
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          bit_valid,
    input  logic [NCH-1:0]          bit_data,
    output logic [NCH-1:0]          bit_ready,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH-1:0]          ch_clr,
    output logic                    hit_valid,
    output logic [$clog2(NCH)-1:0]  hit_ch,
    input  logic [$clog2(NCH)-1:0]  cnt_sel,
    output logic [CNT_W-1:0]        cnt_rdata
);

    localparam int IW = $clog2(NCH);

    state_t           r_ctx [NCH];
    logic [CNT_W-1:0] r_cnt [NCH];
    logic             r_hit_valid;
    logic [IW-1:0]    r_hit_ch;

    logic [NCH-1:0]   w_elig;
    logic [NCH-1:0]   w_grant;
    logic [IW-1:0]    w_gidx;
    logic             w_gvld;
    state_t           w_step [NCH];
    logic [NCH-1:0]   w_hit;

    // A clear masks its channel so clear always beats a grant.
    assign w_elig = bit_valid & ch_en & ~ch_clr;

    rr_arb #(
        .N  (NCH),
        .IW (IW)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_elig      (w_elig),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_vld (w_gvld)
    );

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            w_step[i] = seq_step(r_ctx[i], bit_data[i]);
            w_hit[i]  = w_grant[i] & is_hit(w_step[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= S0;
                r_cnt[i] <= '0;
            end
            r_hit_valid <= 1'b0;
            r_hit_ch    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    r_ctx[i] <= S0;
                    r_cnt[i] <= '0;
                end else if (w_grant[i]) begin
                    r_ctx[i] <= w_step[i];
                    if (w_hit[i] && (r_cnt[i] != '1)) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
            r_hit_valid <= |w_hit;
            if (|w_hit) begin
                r_hit_ch <= w_gidx;
            end
        end
    end

    always_comb begin
        cnt_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_sel == IW'(i)) begin
                cnt_rdata = r_cnt[i];
            end
        end
    end

    assign bit_ready = w_grant & {NCH{w_gvld}};
    assign hit_valid = r_hit_valid;
    assign hit_ch    = r_hit_ch;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: directed scenarios plus a
// randomized run against a run-length based reference model.
module tb_seq_detect_sched;

    localparam int NCH   = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   bit_valid = '0;
    logic [NCH-1:0]   bit_data = '0;
    logic [NCH-1:0]   bit_ready;
    logic [NCH-1:0]   ch_en = '0;
    logic [NCH-1:0]   ch_clr = '0;
    logic             hit_valid;
    logic [1:0]       hit_ch;
    logic [1:0]       cnt_sel = '0;
    logic [CNT_W-1:0] cnt_rdata;

    int n_checks = 0;
    int n_fail = 0;

    seq_detect_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .ch_en     (ch_en),
        .ch_clr    (ch_clr),
        .hit_valid (hit_valid),
        .hit_ch    (hit_ch),
        .cnt_sel   (cnt_sel),
        .cnt_rdata (cnt_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: m_run counts consecutive accepted ones since the
    // last zero or clear (capped at 3); a hit is the run reaching exactly 2.
    int m_run [NCH];
    int m_cnt [NCH];
    int m_ptr;
    bit m_hv;
    int m_hc;

    function automatic int model_grant();
        for (int k = 0; k < NCH; k++) begin
            if (bit_valid[(m_ptr + k) % NCH] && ch_en[(m_ptr + k) % NCH] &&
                !ch_clr[(m_ptr + k) % NCH])
                return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic int next_run(input int ch);
        if (!bit_data[ch]) return 0;
        return (m_run[ch] >= 3) ? 3 : m_run[ch] + 1;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_run[i] <= 0;
                m_cnt[i] <= 0;
            end
            m_ptr <= 0;
            m_hv  <= 1'b0;
            m_hc  <= 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    m_run[i] <= 0;
                    m_cnt[i] <= 0;
                end
            end
            if (model_grant() >= 0) begin
                m_run[model_grant()] <= next_run(model_grant());
                m_hv <= (next_run(model_grant()) == 2);
                if (next_run(model_grant()) == 2) begin
                    m_hc <= model_grant();
                    m_cnt[model_grant()] <= sat_inc(m_cnt[model_grant()]);
                end
                m_ptr <= (model_grant() + 1) % NCH;
            end else begin
                m_hv <= 1'b0;
            end
        end
    end

    // Drive one cycle of inputs on the falling edge, then settle before sampling.
    task automatic cyc(input logic [3:0] v, input logic [3:0] d,
                       input logic [3:0] en, input logic [3:0] clr);
        @(negedge clk);
        bit_valid = v;
        bit_data  = d;
        ch_en     = en;
        ch_clr    = clr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bit_valid = '0; bit_data = '0; ch_en = '0; ch_clr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hit_valid: got %b expected 0", hit_valid); end
        n_checks++;
        if (hit_ch !== 2'd0) begin n_fail++; $display("FAIL reset_hit_ch: got %0d expected 0", hit_ch); end
        n_checks++;
        if (bit_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bit_ready); end
        for (int s = 0; s < NCH; s++) begin
            cnt_sel = 2'(s);
            #1;
            n_checks++;
            if (cnt_rdata !== '0) begin n_fail++; $display("FAIL reset_cnt ch%0d: got %0d expected 0", s, cnt_rdata); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'hF, 4'h0, 4'hF, 4'h0);
        n_checks++;
        if (bit_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", bit_ready); end
    endtask

    task automatic test_single();
        logic [6:0] pat;
        logic       v;
        logic       exp_hv;
        int         hits;
        pat  = 7'b1101110;
        hits = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            v = (k < 7);
            cyc({3'b000, v}, {3'b000, (k < 7) ? pat[k % 7] : 1'b0}, 4'b0001, 4'b0000);
            exp_hv = (k == 3) || (k == 7);
            n_checks++;
            if (bit_ready !== {3'b000, v}) begin n_fail++; $display("FAIL single_ready k=%0d: got %b expected %b", k, bit_ready, {3'b000, v}); end
            n_checks++;
            if (hit_valid !== exp_hv) begin n_fail++; $display("FAIL single_hit k=%0d: got %b expected %b", k, hit_valid, exp_hv); end
            if (hit_valid === 1'b1) begin
                hits++;
                n_checks++;
                if (hit_ch !== 2'd0) begin n_fail++; $display("FAIL single_hit_ch k=%0d: got %0d expected 0", k, hit_ch); end
            end
        end
        n_checks++;
        if (hits != 2) begin n_fail++; $display("FAIL single_hit_count: got %0d expected 2", hits); end
        cnt_sel = 2'd0;
        #1;
        n_checks++;
        if (cnt_rdata !== 2'd2) begin n_fail++; $display("FAIL single_cnt: got %0d expected 2", cnt_rdata); end
    endtask

    task automatic test_fairness();
        int         seq3 [3];
        logic [3:0] exp;
        seq3 = '{0, 1, 3};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(4'hF, 4'h0, 4'hF, 4'h0);
            exp = 4'b0001 << (k % 4);
            n_checks++;
            if (bit_ready !== exp) begin n_fail++; $display("FAIL fair_all k=%0d: got %b expected %b", k, bit_ready, exp); end
        end
        for (int k = 0; k < 6; k++) begin
            cyc(4'hF, 4'h0, 4'b1011, 4'h0);
            exp = 4'b0001 << seq3[k % 3];
            n_checks++;
            if (bit_ready !== exp) begin n_fail++; $display("FAIL fair_ch2_off k=%0d: got %b expected %b", k, bit_ready, exp); end
        end
    endtask

    task automatic test_isolation();
        do_reset();
        cyc(4'b0010, 4'b0010, 4'hF, 4'h0);
        n_checks++;
        if (bit_ready !== 4'b0010) begin n_fail++; $display("FAIL iso_ready1: got %b expected 0010", bit_ready); end
        cyc(4'b1000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (bit_ready !== 4'b1000) begin n_fail++; $display("FAIL iso_ready3: got %b expected 1000", bit_ready); end
        cyc(4'b0010, 4'b0010, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL iso_nohit: got %b expected 0", hit_valid); end
        cyc(4'b0000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b1 || hit_ch !== 2'd1) begin n_fail++; $display("FAIL iso_hit_ch1: got valid=%b ch=%0d expected valid=1 ch=1", hit_valid, hit_ch); end
        cnt_sel = 2'd3;
        #1;
        n_checks++;
        if (cnt_rdata !== 2'd0) begin n_fail++; $display("FAIL iso_cnt3: got %0d expected 0", cnt_rdata); end
        cnt_sel = 2'd1;
        #1;
        n_checks++;
        if (cnt_rdata !== 2'd1) begin n_fail++; $display("FAIL iso_cnt1: got %0d expected 1", cnt_rdata); end
        // A single 1 on ch3 must not hit, showing its context was still S0.
        cyc(4'b1000, 4'b1000, 4'hF, 4'h0);
        cyc(4'b0000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL iso_ch3_s0: got %b expected 0", hit_valid); end
        cyc(4'b1000, 4'b1000, 4'hF, 4'h0);
        cyc(4'b0000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b1 || hit_ch !== 2'd3) begin n_fail++; $display("FAIL iso_hit_ch3: got valid=%b ch=%0d expected valid=1 ch=3", hit_valid, hit_ch); end
    endtask

    task automatic test_clear();
        do_reset();
        cnt_sel = 2'd0;
        cyc(4'b0001, 4'b0001, 4'b0001, 4'h0);
        cyc(4'b0001, 4'b0001, 4'b0001, 4'h0);
        cyc(4'b0001, 4'b0000, 4'b0001, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL clr_prehit: got %b expected 1", hit_valid); end
        cyc(4'b0001, 4'b0001, 4'b0001, 4'h0);
        n_checks++;
        if (cnt_rdata !== 2'd1) begin n_fail++; $display("FAIL clr_precnt: got %0d expected 1", cnt_rdata); end
        cyc(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        n_checks++;
        if (bit_ready !== 4'b0000) begin n_fail++; $display("FAIL clr_ready: got %b expected 0000", bit_ready); end
        cyc(4'b0001, 4'b0001, 4'b0001, 4'h0);
        n_checks++;
        if (cnt_rdata !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", cnt_rdata); end
        n_checks++;
        if (bit_ready !== 4'b0001) begin n_fail++; $display("FAIL clr_ready_after: got %b expected 0001", bit_ready); end
        cyc(4'b0001, 4'b0001, 4'b0001, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL clr_first_one: got %b expected 0", hit_valid); end
        cyc(4'b0000, 4'b0000, 4'b0001, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b1 || hit_ch !== 2'd0) begin n_fail++; $display("FAIL clr_second_one: got valid=%b ch=%0d expected valid=1 ch=0", hit_valid, hit_ch); end
    endtask

    task automatic test_saturation();
        int h;
        h = 0;
        do_reset();
        cnt_sel = 2'd0;
        for (int k = 0; k < 17; k++) begin
            if (k < 15)
                cyc(4'b0001, {3'b000, (k % 3) != 0}, 4'b0001, 4'h0);
            else
                cyc(4'b0000, 4'b0000, 4'b0001, 4'h0);
            if (hit_valid === 1'b1) begin
                h++;
                n_checks++;
                if (cnt_rdata !== 2'((h > CMAX) ? CMAX : h)) begin n_fail++; $display("FAIL sat_cnt hit=%0d: got %0d expected %0d", h, cnt_rdata, (h > CMAX) ? CMAX : h); end
            end
        end
        n_checks++;
        if (h != 5) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 5", h); end
        cyc(4'b0000, 4'b0000, 4'b0001, 4'h0);
        n_checks++;
        if (cnt_rdata !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d expected 3", cnt_rdata); end
    endtask

    task automatic test_random();
        int         g;
        logic [3:0] exp;
        logic [3:0] clr;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            cnt_sel = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            cyc(4'($urandom), 4'($urandom | $urandom), 4'($urandom | $urandom), clr);
            g = model_grant();
            exp = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            n_checks++;
            if (bit_ready !== exp) begin n_fail++; $display("FAIL rnd_ready k=%0d: got %b expected %b", k, bit_ready, exp); end
            n_checks++;
            if (hit_valid !== m_hv) begin n_fail++; $display("FAIL rnd_hit k=%0d: got %b expected %b", k, hit_valid, m_hv); end
            if (m_hv) begin
                n_checks++;
                if (hit_ch !== 2'(m_hc)) begin n_fail++; $display("FAIL rnd_hit_ch k=%0d: got %0d expected %0d", k, hit_ch, m_hc); end
            end
            n_checks++;
            if (cnt_rdata !== 2'(m_cnt[cnt_sel])) begin n_fail++; $display("FAIL rnd_cnt k=%0d sel=%0d: got %0d expected %0d", k, cnt_sel, cnt_rdata, m_cnt[cnt_sel]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(4'b0001, 4'b0001, 4'hF, 4'h0);
        cyc(4'b0010, 4'b0010, 4'hF, 4'h0);
        cyc(4'b0010, 4'b0010, 4'hF, 4'h0);
        cyc(4'b0000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b1 || hit_ch !== 2'd1) begin n_fail++; $display("FAIL arst_prehit: got valid=%b ch=%0d expected valid=1 ch=1", hit_valid, hit_ch); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_hit_drop: got %b expected 0", hit_valid); end
        cnt_sel = 2'd1;
        #1;
        n_checks++;
        if (cnt_rdata !== 2'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d expected 0", cnt_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'hF, 4'h0, 4'hF, 4'h0);
        n_checks++;
        if (bit_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_first_grant: got %b expected 0001", bit_ready); end
        cyc(4'b0001, 4'b0001, 4'hF, 4'h0);
        cyc(4'b0000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_single_one: got %b expected 0", hit_valid); end
        cyc(4'b0001, 4'b0001, 4'hF, 4'h0);
        cyc(4'b0000, 4'b0000, 4'hF, 4'h0);
        n_checks++;
        if (hit_valid !== 1'b1 || hit_ch !== 2'd0) begin n_fail++; $display("FAIL arst_second_one: got valid=%b ch=%0d expected valid=1 ch=0", hit_valid, hit_ch); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_isolation();
        test_clear();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
